// File: rtl/log_domain_adder_16_mul_div_if.sv
// Operand/control and result bundle for the log-domain adder front end.
// The slave side is the adder itself; the master side is whoever feeds and drains it.
interface log_domain_adder_16_mul_div_if #(
    parameter int N   = 16,
    parameter int LGN = 4
);
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [1:0]     func;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;

    logic           out_valid;
    logic           out_ready;
    logic           mode_o;
    logic [1:0]     func_o;
    logic [N-1:0]   a;
    logic [LGN+1:0] shift_upper;
    logic [LGN:0]   shift_lower;
    logic [1:0]     res_zero;
    logic [1:0]     div_by_zero;

    modport master (
        output in_valid, mode, func, op_a, op_b, out_ready,
        input  in_ready, out_valid, mode_o, func_o, a,
               shift_upper, shift_lower, res_zero, div_by_zero
    );

    modport slave (
        input  in_valid, mode, func, op_a, op_b, out_ready,
        output in_ready, out_valid, mode_o, func_o, a,
               shift_upper, shift_lower, res_zero, div_by_zero
    );
endinterface

// File: rtl/log_domain_adder_16_mul_div.sv
// Mitchell log-domain front end: leading-one detect/normalise, then add (mul) or subtract (div) logs.
// Latency: 2 cycles (S1 LOD register, S2 add/sub register), 1 word/cycle.
// Backpressure: valid/ready; in_ready = !s1_valid || s2_take, combinational from out_ready.
module log_domain_adder_16_mul_div #(
    parameter int N   = 16,
    parameter int LGN = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    log_domain_adder_16_mul_div_if.slave      bus
);
    localparam int H = N / 2;

    // The upper/whole lane shares one datapath: in dual mode the upper-lane fraction is
    // parked in the top bits so its carry/borrow lands in the same place as a full word's.
    typedef struct packed {
        logic           mode;
        logic [1:0]     func;
        logic [LGN-1:0] ka_hi;
        logic [LGN-1:0] kb_hi;
        logic [N-2:0]   fa_hi;
        logic [N-2:0]   fb_hi;
        logic [LGN-2:0] ka_lo;
        logic [LGN-2:0] kb_lo;
        logic [H-2:0]   fa_lo;
        logic [H-2:0]   fb_lo;
        logic [1:0]     za;
        logic [1:0]     zb;
    } s1_t;

    function automatic logic [LGN-1:0] lod_w(input logic [N-1:0] x);
        logic [LGN-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++)
            if (x[i]) k = LGN'(i);
        return k;
    endfunction

    function automatic logic [N-2:0] frac_w(input logic [N-1:0] x, input logic [LGN-1:0] k);
        logic [N-1:0] t;
        t = x << (LGN'(N - 1) - k);
        return t[N-2:0];
    endfunction

    function automatic logic [LGN-2:0] lod_h(input logic [H-1:0] x);
        logic [LGN-2:0] k;
        k = '0;
        for (int i = 0; i < H; i++)
            if (x[i]) k = (LGN-1)'(i);
        return k;
    endfunction

    function automatic logic [H-2:0] frac_h(input logic [H-1:0] x, input logic [LGN-2:0] k);
        logic [H-1:0] t;
        t = x << ((LGN-1)'(H - 1) - k);
        return t[H-2:0];
    endfunction

    // ---------------- pipeline control ----------------
    logic s1_valid;
    logic out_valid_q;
    logic s2_take;
    logic in_ready_i;
    logic s1_load;
    logic s2_load;

    assign s2_take    = !out_valid_q || bus.out_ready;
    assign in_ready_i = !s1_valid || s2_take;
    assign s1_load    = bus.in_valid && in_ready_i;
    assign s2_load    = s1_valid && s2_take;

    // ---------------- stage 1: LOD / normalise ----------------
    s1_t            s1_nxt;
    s1_t            s1_q;
    logic [LGN-1:0] ka_w;
    logic [LGN-1:0] kb_w;
    logic [LGN-2:0] ka_u;
    logic [LGN-2:0] kb_u;
    logic [LGN-2:0] ka_l;
    logic [LGN-2:0] kb_l;

    always_comb begin
        ka_w = lod_w(bus.op_a);
        kb_w = lod_w(bus.op_b);
        ka_u = lod_h(bus.op_a[N-1:H]);
        kb_u = lod_h(bus.op_b[N-1:H]);
        ka_l = lod_h(bus.op_a[H-1:0]);
        kb_l = lod_h(bus.op_b[H-1:0]);

        s1_nxt      = '0;
        s1_nxt.mode = bus.mode;
        s1_nxt.func = bus.func;
        if (bus.mode) begin
            s1_nxt.ka_hi = {1'b0, ka_u};
            s1_nxt.kb_hi = {1'b0, kb_u};
            s1_nxt.fa_hi = {frac_h(bus.op_a[N-1:H], ka_u), {H{1'b0}}};
            s1_nxt.fb_hi = {frac_h(bus.op_b[N-1:H], kb_u), {H{1'b0}}};
            s1_nxt.za    = {~|bus.op_a[N-1:H], ~|bus.op_a[H-1:0]};
            s1_nxt.zb    = {~|bus.op_b[N-1:H], ~|bus.op_b[H-1:0]};
        end else begin
            s1_nxt.ka_hi = ka_w;
            s1_nxt.kb_hi = kb_w;
            s1_nxt.fa_hi = frac_w(bus.op_a, ka_w);
            s1_nxt.fb_hi = frac_w(bus.op_b, kb_w);
            s1_nxt.za    = {2{~|bus.op_a}};
            s1_nxt.zb    = {2{~|bus.op_b}};
        end
        s1_nxt.ka_lo = ka_l;
        s1_nxt.kb_lo = kb_l;
        s1_nxt.fa_lo = frac_h(bus.op_a[H-1:0], ka_l);
        s1_nxt.fb_lo = frac_h(bus.op_b[H-1:0], kb_l);
    end

    // ---------------- stage 2: add / subtract logs ----------------
    logic           div;
    logic [N-1:0]   add_hi;
    logic [N-1:0]   sub_hi;
    logic [H-1:0]   add_lo;
    logic [H-1:0]   sub_lo;
    logic           cy_hi;
    logic           cy_lo;
    logic [N-2:0]   fr_hi;
    logic [H-2:0]   fr_lo;
    logic [LGN+1:0] k_hi;
    logic [LGN:0]   k_lo;
    logic           rz_hi;
    logic           rz_lo;
    logic           dz_hi;
    logic           dz_lo;
    logic [N-1:0]   a_nxt;
    logic [LGN+1:0] su_nxt;
    logic [LGN:0]   sl_nxt;
    logic [1:0]     rz_nxt;
    logic [1:0]     dz_nxt;

    always_comb begin
        div    = s1_q.func[0];
        add_hi = {1'b0, s1_q.fa_hi} + {1'b0, s1_q.fb_hi};
        sub_hi = {1'b0, s1_q.fa_hi} - {1'b0, s1_q.fb_hi};
        add_lo = {1'b0, s1_q.fa_lo} + {1'b0, s1_q.fb_lo};
        sub_lo = {1'b0, s1_q.fa_lo} - {1'b0, s1_q.fb_lo};

        // Top bit is the fraction carry (mul) or borrow (div); the low bits are already mod 2^(W-1).
        cy_hi = div ? sub_hi[N-1]   : add_hi[N-1];
        fr_hi = div ? sub_hi[N-2:0] : add_hi[N-2:0];
        cy_lo = div ? sub_lo[H-1]   : add_lo[H-1];
        fr_lo = div ? sub_lo[H-2:0] : add_lo[H-2:0];

        if (div) begin
            k_hi = {2'b00, s1_q.ka_hi} - {2'b00, s1_q.kb_hi} - {{(LGN+1){1'b0}}, cy_hi};
            k_lo = {2'b00, s1_q.ka_lo} - {2'b00, s1_q.kb_lo} - {{LGN{1'b0}}, cy_lo};
        end else begin
            k_hi = {2'b00, s1_q.ka_hi} + {2'b00, s1_q.kb_hi} + {{(LGN+1){1'b0}}, cy_hi};
            k_lo = {2'b00, s1_q.ka_lo} + {2'b00, s1_q.kb_lo} + {{LGN{1'b0}}, cy_lo};
        end

        dz_hi = div & s1_q.zb[1];
        dz_lo = div & s1_q.zb[0];
        rz_hi = s1_q.za[1] | s1_q.zb[1] | (div & k_hi[LGN+1]);
        rz_lo = s1_q.za[0] | s1_q.zb[0] | (div & k_lo[LGN]);

        a_nxt  = '0;
        su_nxt = '0;
        sl_nxt = '0;
        if (!rz_hi)
            su_nxt = k_hi;
        if (s1_q.mode) begin
            rz_nxt = {rz_hi, rz_lo};
            dz_nxt = {dz_hi, dz_lo};
            if (!rz_hi)
                a_nxt[N-2:H] = fr_hi[N-2:H];
            if (!rz_lo) begin
                a_nxt[H-2:0] = fr_lo;
                sl_nxt       = k_lo;
            end
        end else begin
            rz_nxt = {2{rz_hi}};
            dz_nxt = {2{dz_hi}};
            if (!rz_hi)
                a_nxt[N-2:0] = fr_hi;
        end
    end

    // ---------------- registers ----------------
    logic           mode_q;
    logic [1:0]     func_q;
    logic [N-1:0]   a_q;
    logic [LGN+1:0] su_q;
    logic [LGN:0]   sl_q;
    logic [1:0]     rz_q;
    logic [1:0]     dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            func_q      <= '0;
            a_q         <= '0;
            su_q        <= '0;
            sl_q        <= '0;
            rz_q        <= '0;
            dz_q        <= '0;
        end else begin
            if (in_ready_i)
                s1_valid <= bus.in_valid;
            if (s1_load)
                s1_q <= s1_nxt;
            if (s2_take)
                out_valid_q <= s1_valid;
            if (s2_load) begin
                mode_q <= s1_q.mode;
                func_q <= s1_q.func;
                a_q    <= a_nxt;
                su_q   <= su_nxt;
                sl_q   <= sl_nxt;
                rz_q   <= rz_nxt;
                dz_q   <= dz_nxt;
            end
        end
    end

    assign bus.in_ready    = in_ready_i;
    assign bus.out_valid   = out_valid_q;
    assign bus.mode_o      = mode_q;
    assign bus.func_o      = func_q;
    assign bus.a           = a_q;
    assign bus.shift_upper = su_q;
    assign bus.shift_lower = sl_q;
    assign bus.res_zero    = rz_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_log_domain_adder_16_mul_div.sv
// Directed bench for the log-domain adder: vector table, backpressure and mid-stream reset.
module tb_log_domain_adder_16_mul_div;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    log_domain_adder_16_mul_div_if #(.N(16), .LGN(4)) bus ();

    log_domain_adder_16_mul_div #(.N(16), .LGN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        mode;
        logic [1:0]  func;
        logic [15:0] op_a;
        logic [15:0] op_b;
        logic [15:0] a;
        logic [5:0]  su;
        logic [4:0]  sl;
        logic [1:0]  rz;
        logic [1:0]  dz;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.mode     = v.mode;
        bus.func     = v.func;
        bus.op_a     = v.op_a;
        bus.op_b     = v.op_b;
    endtask

    task automatic check_out(input vec_t v);
        check({v.name, "/a"},           32'(bus.a),           32'(v.a));
        check({v.name, "/shift_upper"}, 32'(bus.shift_upper), 32'(v.su));
        check({v.name, "/shift_lower"}, 32'(bus.shift_lower), 32'(v.sl));
        check({v.name, "/res_zero"},    32'(bus.res_zero),    32'(v.rz));
        check({v.name, "/div_by_zero"}, 32'(bus.div_by_zero), 32'(v.dz));
        check({v.name, "/mode_o"},      32'(bus.mode_o),      32'(v.mode));
        check({v.name, "/func_o"},      32'(bus.func_o),      32'(v.func));
    endtask

    int   lat;
    int   idx;
    int   rx;
    int   acc_cnt;
    int   extra;
    logic acc;
    int   bp_list[4];

    initial begin
        //           name            mode func   op_a      op_b      a         su     sl     rz     dz
        vecs[0]  = '{"mul12x10",     1'b0, 2'b00, 16'd12,   16'd10,   16'h6000, 6'd6,  5'd0,  2'b00, 2'b00};
        vecs[1]  = '{"div100by7",    1'b0, 2'b01, 16'd100,  16'd7,    16'h6800, 6'd3,  5'd0,  2'b00, 2'b00};
        vecs[2]  = '{"simd_mul",     1'b1, 2'b00, 16'h0503, 16'h0603, 16'h6000, 6'd4,  5'd3,  2'b00, 2'b00};
        vecs[3]  = '{"simd_div_err", 1'b1, 2'b01, 16'h0309, 16'h0700, 16'h0000, 6'd0,  5'd0,  2'b11, 2'b01};
        vecs[4]  = '{"mul_zero",     1'b0, 2'b00, 16'd0,    16'd5,    16'h0000, 6'd0,  5'd0,  2'b11, 2'b00};
        vecs[5]  = '{"div_by_zero",  1'b0, 2'b01, 16'd5,    16'd0,    16'h0000, 6'd0,  5'd0,  2'b11, 2'b11};
        vecs[6]  = '{"mul_max",      1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 16'h7FFE, 6'd31, 5'd0,  2'b00, 2'b00};
        vecs[7]  = '{"div_neg_k",    1'b0, 2'b01, 16'd1,    16'd2,    16'h0000, 6'd0,  5'd0,  2'b11, 2'b00};
        vecs[8]  = '{"div_big",      1'b0, 2'b01, 16'h8000, 16'd1,    16'h0000, 6'd15, 5'd0,  2'b00, 2'b00};
        vecs[9]  = '{"simd_mul_max", 1'b1, 2'b00, 16'hFFFF, 16'hFFFF, 16'h7E7E, 6'd15, 5'd15, 2'b00, 2'b00};
        vecs[10] = '{"func1_fwd",    1'b0, 2'b10, 16'd3,    16'd3,    16'h0000, 6'd3,  5'd0,  2'b00, 2'b00};
        vecs[11] = '{"simd_div",     1'b1, 2'b01, 16'h0703, 16'h0302, 16'h2040, 6'd1,  5'd0,  2'b00, 2'b00};
        vecs[12] = '{"simd_lo_zero", 1'b1, 2'b00, 16'h0200, 16'h0305, 16'h4000, 6'd2,  5'd0,  2'b01, 2'b00};
        bp_list = '{0, 1, 2, 9};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.func      = 2'b00;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset/out_valid",   32'(bus.out_valid),   0);
        check("reset/in_ready",    32'(bus.in_ready),    1);
        check("reset/a",           32'(bus.a),           0);
        check("reset/shift_upper", 32'(bus.shift_upper), 0);
        check("reset/shift_lower", 32'(bus.shift_lower), 0);
        check("reset/res_zero",    32'(bus.res_zero),    0);
        check("reset/div_by_zero", 32'(bus.div_by_zero), 0);
        check("reset/mode_func",   32'({bus.mode_o, bus.func_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single words through an idle pipeline: latency and datapath per vector.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
                if (lat == 1) bus.in_valid = 1'b0;
            end while (!bus.out_valid && lat < 8);
            check({vecs[i].name, "/latency"}, 32'(lat), 2);
            check_out(vecs[i]);
        end
        @(posedge clk);
        #1;

        // Backpressure: out_ready low for the first cycles while four words stream in.
        idx     = 0;
        rx      = 0;
        acc_cnt = 0;
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (idx < 4) drive(vecs[bp_list[idx]]);
            else         bus.in_valid = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp/in_ready_low",  32'(bus.in_ready),    0);
                check("bp/accepted",      32'(acc_cnt),         2);
                check("bp/out_valid_held", 32'(bus.out_valid),  1);
                check("bp/frozen_a",      32'(bus.a),           32'(vecs[bp_list[0]].a));
                check("bp/frozen_su",     32'(bus.shift_upper), 32'(vecs[bp_list[0]].su));
            end
            if (cyc == 5)
                check("bp/in_ready_release", 32'(bus.in_ready), 1);
            if (bus.out_valid && bus.out_ready) begin
                if (rx < 4) check_out(vecs[bp_list[rx]]);
                rx++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                acc_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        check("bp/words_out", 32'(rx), 4);
        extra = 0;
        repeat (3) begin
            #1;
            if (bus.out_valid) extra++;
            @(posedge clk);
            #1;
        end
        check("bp/no_duplicate", 32'(extra), 0);

        // Mid-stream asynchronous reset with both stages full.
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        drive(vecs[1]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        check("rst/pre_out_valid", 32'(bus.out_valid), 1);
        check("rst/pre_in_ready",  32'(bus.in_ready),  0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst/out_valid",   32'(bus.out_valid),   0);
        check("rst/in_ready",    32'(bus.in_ready),    1);
        check("rst/a",           32'(bus.a),           0);
        check("rst/shift_upper", 32'(bus.shift_upper), 0);
        check("rst/res_zero",    32'(bus.res_zero),    0);
        #1;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) extra++;
        end
        check("rst/no_stale_word", 32'(extra), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
